// File: rtl/fft_seq_pkg.sv
// Shared types and bus constants for the FFT scan sequencer.
// Bus widths match the global RD/WR/Addr/Data bus of the butterfly array.
package fft_seq_pkg;

    localparam int unsigned GlobalAddrWidth = 15;
    localparam int unsigned GlobalDataWidth = 32;

    localparam logic [GlobalAddrWidth-1:0] BusAddrIdle = '0;
    localparam logic [GlobalDataWidth-1:0] BusDataIdle = '0;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StArm,
        StPoll,
        StUnload,
        StDone
    } seq_state_e;

endpackage

// File: rtl/fft_seq_word_cnt.sv
// Scan word counter shared by the load and unload phases.
// Saturates at MaxCount; hit is an exact compare against MaxCount.
module fft_seq_word_cnt #(
    parameter int unsigned MaxCount = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int unsigned Width = $clog2(MaxCount) + 1;

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    assign hit_o = (cnt_q == Width'(MaxCount));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_scan_sequencer.sv
// Bus master that scan-loads the FFT array, runs it for a programmed count,
// polls for completion and scan-unloads the results to a host stream.
module fft_scan_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned SIZE     = 2,
    parameter int unsigned IDWIDTH  = 1,
    parameter int unsigned SCAN_LEN = 8,
    parameter int unsigned CTRL_ID  = 0,
    parameter int unsigned SCAN_ID  = 1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       start,
    input  logic [GlobalDataWidth-1:0] run_cycles,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    input  logic [SIZE-1:0]            in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [SIZE-1:0]            out_data,
    input  logic                       out_ready,
    output logic                       BusRD,
    output logic                       BusWR,
    output logic [GlobalAddrWidth-1:0] BusAddr,
    output logic [GlobalDataWidth-1:0] BusDataOut,
    input  logic [GlobalDataWidth-1:0] BusDataIn
);

    localparam logic [IDWIDTH-1:0] CtrlId = IDWIDTH'(CTRL_ID);
    localparam logic [IDWIDTH-1:0] ScanId = IDWIDTH'(SCAN_ID);
    localparam logic [GlobalAddrWidth-1:0] CtrlAddr = GlobalAddrWidth'(CtrlId);
    localparam logic [GlobalAddrWidth-1:0] ScanAddr = GlobalAddrWidth'(ScanId);

    seq_state_e                 state_q, state_d;
    logic [GlobalDataWidth-1:0] run_q, run_d;
    logic                       bus_rd_q, bus_rd_d;
    logic                       bus_wr_q, bus_wr_d;
    logic [GlobalAddrWidth-1:0] bus_addr_q, bus_addr_d;
    logic [GlobalDataWidth-1:0] bus_dout_q, bus_dout_d;
    logic                       out_valid_q, out_valid_d;
    logic [SIZE-1:0]            out_data_q, out_data_d;
    logic                       cnt_clr, cnt_inc, cnt_hit;

    fft_seq_word_cnt #(
        .MaxCount(SCAN_LEN)
    ) u_word_cnt (
        .clk_i(Clk),
        .rst_i(Reset),
        .clr_i(cnt_clr),
        .inc_i(cnt_inc),
        .hit_o(cnt_hit)
    );

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);
    assign in_ready   = (state_q == StLoad) && !cnt_hit;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign BusRD      = bus_rd_q;
    assign BusWR      = bus_wr_q;
    assign BusAddr    = bus_addr_q;
    assign BusDataOut = bus_dout_q;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        bus_rd_d    = 1'b0;
        bus_wr_d    = 1'b0;
        bus_addr_d  = BusAddrIdle;
        bus_dout_d  = BusDataIdle;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    run_d   = run_cycles;
                    cnt_clr = 1'b1;
                end
            end
            StLoad: begin
                if (cnt_hit) begin
                    state_d = StArm;
                end else if (in_valid) begin
                    bus_wr_d   = 1'b1;
                    bus_addr_d = ScanAddr;
                    bus_dout_d = GlobalDataWidth'(in_data);
                    cnt_inc    = 1'b1;
                end
            end
            StArm: begin
                // Counter is idle until UNLOAD, so clearing here covers both exits.
                cnt_clr = 1'b1;
                if (run_q == '0) begin
                    state_d = StUnload;
                end else begin
                    bus_wr_d   = 1'b1;
                    bus_addr_d = CtrlAddr;
                    bus_dout_d = run_q;
                    state_d    = StPoll;
                end
            end
            StPoll: begin
                // Stop issuing the moment a zero sample lands so no RD trails into UNLOAD.
                if (bus_rd_q && (BusDataIn == '0)) begin
                    state_d = StUnload;
                end else begin
                    bus_rd_d   = 1'b1;
                    bus_addr_d = CtrlAddr;
                end
            end
            StUnload: begin
                if (bus_rd_q) begin
                    out_data_d  = BusDataIn[SIZE-1:0];
                    out_valid_d = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_inc     = 1'b1;
                end
                if (cnt_hit) begin
                    state_d = StDone;
                end else if (!out_valid_q && !bus_rd_q) begin
                    bus_rd_d   = 1'b1;
                    bus_addr_d = ScanAddr;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            run_q       <= '0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= BusAddrIdle;
            bus_dout_q  <= BusDataIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_dout_q  <= bus_dout_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fft_scan_sequencer.sv
// Directed bench for fft_scan_sequencer with a small behavioural stand-in for the
// butterfly array: 8-word scan chain plus a self-decrementing control count.
module tb_fft_scan_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [31:0] run_cycles;
    logic        busy, done;
    logic        in_valid;
    logic [1:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_data;
    logic        out_ready;
    logic        BusRD, BusWR;
    logic [14:0] BusAddr;
    logic [31:0] BusDataOut;
    logic [31:0] BusDataIn;

    int n_checks = 0;
    int n_errors = 0;

    fft_scan_sequencer #(
        .SIZE(2),
        .IDWIDTH(1),
        .SCAN_LEN(8),
        .CTRL_ID(0),
        .SCAN_ID(1)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .start(start),
        .run_cycles(run_cycles),
        .busy(busy),
        .done(done),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .BusRD(BusRD),
        .BusWR(BusWR),
        .BusAddr(BusAddr),
        .BusDataOut(BusDataOut),
        .BusDataIn(BusDataIn)
    );

    always #5 Clk = ~Clk;

    // Array stand-in: scan chain shifts toward index 0; the count decrements each
    // cycle and one butterfly (a+b, a-b) per node fires as it reaches zero.
    logic [1:0]  chain [8] = '{default: 2'd0};
    logic [31:0] ctrl_cnt = 32'd0;

    assign BusDataIn = !BusRD ? 32'd0 :
                       (BusAddr == 15'd0) ? ctrl_cnt :
                       (BusAddr == 15'd1) ? {30'd0, chain[0]} : 32'd0;

    always @(posedge Clk) begin
        if (BusWR && BusAddr == 15'd1) begin
            for (int i = 0; i < 7; i++) chain[i] <= chain[i+1];
            chain[7] <= BusDataOut[1:0];
        end else if (BusRD && BusAddr == 15'd1) begin
            for (int i = 0; i < 7; i++) chain[i] <= chain[i+1];
            chain[7] <= 2'd0;
        end
        if (BusWR && BusAddr == 15'd0) begin
            ctrl_cnt <= BusDataOut;
        end else if (ctrl_cnt != 32'd0) begin
            ctrl_cnt <= ctrl_cnt - 32'd1;
            if (ctrl_cnt == 32'd1) begin
                for (int k = 0; k < 4; k++) begin
                    chain[2*k]   <= chain[2*k] + chain[2*k+1];
                    chain[2*k+1] <= chain[2*k] - chain[2*k+1];
                end
            end
        end
    end

    // Bus monitor
    int         viol_excl = 0, viol_busy = 0, viol_idle = 0;
    int         done_cnt = 0, ctrl_wr_cnt = 0, scan_wr_cnt = 0, scan_rd_cnt = 0;
    logic [31:0] ctrl_wr_last = 32'd0;
    logic [31:0] poll_q[$];

    always @(negedge Clk) begin
        if (BusRD && BusWR) viol_excl++;
        if (!busy && (BusRD || BusWR)) viol_busy++;
        if (!BusRD && !BusWR && (BusAddr != 15'd0 || BusDataOut != 32'd0)) viol_idle++;
        if (done) done_cnt++;
        if (BusWR && BusAddr == 15'd0) begin
            ctrl_wr_cnt++;
            ctrl_wr_last = BusDataOut;
        end
        if (BusWR && BusAddr == 15'd1) scan_wr_cnt++;
        if (BusRD && BusAddr == 15'd1) scan_rd_cnt++;
        if (BusRD && BusAddr == 15'd0) poll_q.push_back(BusDataIn);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk8(input int w0, input int w1, input int w2, input int w3,
                                        input int w4, input int w5, input int w6, input int w7);
        return {w7[1:0], w6[1:0], w5[1:0], w4[1:0], w3[1:0], w2[1:0], w1[1:0], w0[1:0]};
    endfunction

    task automatic start_job(input logic [31:0] run);
        start = 1'b1;
        run_cycles = run;
        @(negedge Clk);
        start = 1'b0;
        run_cycles = 32'd0;
    endtask

    task automatic feed(input logic [15:0] words, input bit gap);
        for (int i = 0; i < 8; i++) begin
            int t;
            t = 0;
            in_valid = 1'b1;
            in_data  = words[2*i +: 2];
            while (!in_ready && t < 50) begin
                @(negedge Clk);
                t++;
            end
            if (t >= 50) check_eq("in_ready_wait", 32'd0, 32'd1);
            @(negedge Clk);
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 2'd0;
                @(negedge Clk);
            end
        end
        in_valid = 1'b0;
        in_data  = 2'd0;
    endtask

    task automatic collect(input string tag, input logic [15:0] exp, input int stall);
        for (int i = 0; i < 8; i++) begin
            int         t;
            int         bad;
            logic [1:0] held;
            t = 0;
            bad = 0;
            while (!out_valid && t < 400) begin
                @(negedge Clk);
                t++;
            end
            if (t >= 400) check_eq({tag, "_out_valid_wait"}, 32'd0, 32'd1);
            if (i == 0 && stall > 0) begin
                held = out_data;
                for (int s = 0; s < stall; s++) begin
                    @(negedge Clk);
                    if (!out_valid || out_data !== held) bad++;
                end
                check_eq({tag, "_stall_hold"}, bad, 32'd0);
            end
            check_eq($sformatf("%s_word%0d", tag, i), {30'd0, out_data}, {30'd0, exp[2*i +: 2]});
            out_ready = 1'b1;
            @(negedge Clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 200) check_eq({tag, "_done_wait"}, 32'd0, 32'd1);
        repeat (3) @(negedge Clk);
        check_eq({tag, "_done_once"}, done_cnt - d0, 32'd1);
        check_eq({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, cw0, sw0, sr0, pq0, t;

        Reset = 1'b1;
        start = 1'b0;
        run_cycles = 32'd0;
        in_valid = 1'b0;
        in_data = 2'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data", {30'd0, out_data}, 32'd0);
        check_eq("rst_rd", {31'd0, BusRD}, 32'd0);
        check_eq("rst_wr", {31'd0, BusWR}, 32'd0);
        check_eq("rst_addr", {17'd0, BusAddr}, 32'd0);
        check_eq("rst_dout", BusDataOut, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Reset in the middle of UNLOAD
        d0 = done_cnt;
        start_job(32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd1);
        feed(mk8(3, 2, 1, 0, 3, 2, 1, 0), 1'b0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge Clk);
            t++;
        end
        check_eq("t1_first_word", {30'd0, out_data}, 32'd3);
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("t1_rst_rd", {31'd0, BusRD}, 32'd0);
        check_eq("t1_rst_wr", {31'd0, BusWR}, 32'd0);
        check_eq("t1_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_rst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check_eq("t1_no_done", done_cnt - d0, 32'd0);

        // run_cycles=0: plain load/unload, no control write
        d0 = done_cnt; cw0 = ctrl_wr_cnt; pq0 = poll_q.size();
        start_job(32'd0);
        feed(mk8(0, 1, 2, 3, 0, 1, 2, 3), 1'b0);
        collect("t2", mk8(0, 1, 2, 3, 0, 1, 2, 3), 0);
        wait_done("t2", d0);
        check_eq("t2_no_ctrl_wr", ctrl_wr_cnt - cw0, 32'd0);
        check_eq("t2_no_poll", poll_q.size() - pq0, 32'd0);

        // run_cycles=5: one control write, countdown poll, butterfly results
        d0 = done_cnt; cw0 = ctrl_wr_cnt; pq0 = poll_q.size();
        start_job(32'd5);
        feed(mk8(1, 2, 3, 0, 2, 2, 1, 3), 1'b0);
        collect("t3", mk8(3, 3, 3, 3, 0, 0, 0, 2), 0);
        wait_done("t3", d0);
        check_eq("t3_ctrl_wr_cnt", ctrl_wr_cnt - cw0, 32'd1);
        check_eq("t3_ctrl_wr_data", ctrl_wr_last, 32'd5);
        check_eq("t3_poll_len", poll_q.size() - pq0, 32'd6);
        for (int i = 0; i < 6 && pq0 + i < poll_q.size(); i++)
            check_eq($sformatf("t3_poll%0d", i), poll_q[pq0+i], 32'(5 - i));

        // Gapped input stream and a 10-cycle output stall
        d0 = done_cnt; sw0 = scan_wr_cnt; sr0 = scan_rd_cnt; pq0 = poll_q.size();
        start_job(32'd2);
        feed(mk8(2, 1, 0, 3, 3, 1, 2, 0), 1'b1);
        collect("t4", mk8(3, 1, 3, 1, 0, 2, 2, 2), 10);
        wait_done("t4", d0);
        check_eq("t4_scan_wr", scan_wr_cnt - sw0, 32'd8);
        check_eq("t4_scan_rd", scan_rd_cnt - sr0, 32'd8);
        check_eq("t4_poll_len", poll_q.size() - pq0, 32'd3);

        // start pulsed during POLL must be dropped
        d0 = done_cnt; cw0 = ctrl_wr_cnt; pq0 = poll_q.size();
        start_job(32'd3);
        feed(mk8(0, 1, 2, 3, 0, 1, 2, 3), 1'b0);
        t = 0;
        while (!(BusRD && BusAddr == 15'd0) && t < 50) begin
            @(negedge Clk);
            t++;
        end
        check_eq("t5_in_poll", {31'd0, BusRD}, 32'd1);
        start_job(32'd9);
        collect("t5", mk8(1, 3, 1, 3, 1, 3, 1, 3), 0);
        wait_done("t5", d0);
        repeat (10) @(negedge Clk);
        check_eq("t5_single_done", done_cnt - d0, 32'd1);
        check_eq("t5_ctrl_wr_cnt", ctrl_wr_cnt - cw0, 32'd1);
        check_eq("t5_ctrl_wr_data", ctrl_wr_last, 32'd3);
        check_eq("t5_poll_len", poll_q.size() - pq0, 32'd4);

        check_eq("rd_wr_exclusive", viol_excl, 32'd0);
        check_eq("idle_no_strobe", viol_busy, 32'd0);
        check_eq("bus_idle_zero", viol_idle, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
